input_spike_encoder: RTL

- Rate-codes one image into per-timestep input spike vectors for the SNN core.
- Sits directly upstream of the timestep sequencer:
  - drives its valid_ips;
  - consumes its TU_incre and done_core_img.
- Pixels are streamed in once per image. Each timestep, every pixel is compared against an LFSR sample to produce one spike bit.

---
 rtl/input_spike_encoder.sv | 101 ++++++++++
 1 files changed

// File: rtl/input_spike_encoder.sv
// Rate-codes one streamed image into per-timestep spike vectors using a 16-bit Galois LFSR.
// Define SPIKE_SEED_RELOAD_EN to reseed the LFSR at the start of every image.
module input_spike_encoder #(
    parameter int          N_PIX = 784,
    parameter int          PIX_W = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [N_PIX-1:0] spike_vec,
    output logic             valid_ips,
    input  logic             TU_incre,
    input  logic             done_core_img,
    output logic             busy
);
    localparam int              IDX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
    localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]     TAPS     = 16'hB400;

    typedef enum logic [1:0] {LOAD, GEN, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [PIX_W-1:0] pix_mem [N_PIX];
    logic [IDX_W-1:0] idx;
    logic [15:0]      lfsr;
    logic             handshake;
    logic             gen_en;
    logic             last_idx;
    logic             img_done;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    function automatic logic spike_bit(input logic [PIX_W-1:0] sample,
                                       input logic [PIX_W-1:0] pix);
        return sample < pix;
    endfunction

    assign last_idx = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (handshake && last_idx) state_next = GEN;
            GEN:     if (last_idx)              state_next = HOLD;
            HOLD:    if (TU_incre)              state_next = done_core_img ? LOAD : GEN;
            default:                            state_next = LOAD;
        endcase
    end

    always_comb begin
        handshake = (state == LOAD) && pix_valid && pix_ready;
        gen_en    = (state == GEN);
        busy      = (state != LOAD);
        img_done  = (state == HOLD) && TU_incre && done_core_img;
    end

    // Index, LFSR and spike generation; the LFSR advances only while generating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ready <= 1'b0;
            valid_ips <= 1'b0;
            idx       <= '0;
            lfsr      <= SEED_EFF;
            spike_vec <= '0;
        end else begin
            pix_ready <= (state_next == LOAD);
            valid_ips <= gen_en && last_idx;
            if (handshake) begin
                idx <= last_idx ? '0 : idx + 1'b1;
            end else if (gen_en) begin
                spike_vec[idx] <= spike_bit(lfsr[PIX_W-1:0], pix_mem[idx]);
                lfsr           <= lfsr_step(lfsr);
                idx            <= last_idx ? '0 : idx + 1'b1;
            end
            if (img_done) spike_vec <= '0;
`ifdef SPIKE_SEED_RELOAD_EN
            if (handshake && last_idx) lfsr <= SEED_EFF;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PIX; i++) pix_mem[i] <= '0;
        end else if (handshake) begin
            pix_mem[idx] <= pix_in;
        end
    end
endmodule
